icache: RTL and testbench

ICACHE -- requirements
Module: icache

---
 rtl/icache_if.sv | 33 +++
 rtl/icache.sv | 116 +++++++++++
 tb/tb_icache.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_if.sv
`default_nettype none
// ============================================================================
//  Module   : icache_if
//  Purpose  : Datapath and memory-control signal bundle for the icache.
//             The slave modport is the cache side and the master modport is
//             the side that drives requests and memory responses.
//  Revision : 1.0 - initial release
// ============================================================================
interface icache_if #(
  parameter int CNTW = 16
);
  logic            imemREN;
  logic [31:0]     imemaddr;
  logic            flush;
  logic            ihit;
  logic [31:0]     imemload;
  logic            iREN;
  logic [31:0]     iaddr;
  logic            iwait;
  logic [31:0]     iload;
  logic [CNTW-1:0] misscount;

  modport slave (
    input  imemREN, imemaddr, flush, iwait, iload,
    output ihit, imemload, iREN, iaddr, misscount
  );

  modport master (
    output imemREN, imemaddr, flush, iwait, iload,
    input  ihit, imemload, iREN, iaddr, misscount
  );
endinterface
`default_nettype wire

// File: rtl/icache.sv
`default_nettype none
// ============================================================================
//  Module   : icache
//  Purpose  : Direct-mapped, one-word-per-entry instruction cache with a
//             single outstanding memory fetch and a saturating miss counter.
//  Revision : 1.0 - initial release
// ============================================================================
module icache #(
  parameter int SETS = 16,
  parameter int CNTW = 16
) (
  input  logic     CLK,
  input  logic     nRST,
  icache_if.slave  bus
);

  localparam int IDXW = $clog2(SETS);
  localparam int TAGW = 30 - IDXW;
  localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [SETS-1:0] valid_q;
  logic [TAGW-1:0] tag_q  [SETS];
  logic [31:0]     data_q [SETS];
  logic [31:0]     missaddr_q, missaddr_d;
  logic [CNTW-1:0] misscount_q, misscount_d;

  logic [IDXW-1:0] req_idx;
  logic [TAGW-1:0] req_tag;
  logic [IDXW-1:0] miss_idx;
  logic [TAGW-1:0] miss_tag;
  logic            hit;
  logic            fill;

  // The byte offset bits of the request are never looked at.
  assign req_idx  = bus.imemaddr[IDXW+1:2];
  assign req_tag  = bus.imemaddr[31:IDXW+2];
  assign miss_idx = missaddr_q[IDXW+1:2];
  assign miss_tag = missaddr_q[31:IDXW+2];

  // Hits are only reported while no fetch is in flight.
  assign hit = bus.imemREN & (state_q == IDLE) & valid_q[req_idx]
             & (tag_q[req_idx] == req_tag);

  assign bus.ihit      = hit;
  assign bus.imemload  = hit ? data_q[req_idx] : 32'h0;
  assign bus.iREN      = (state_q == FETCH);
  assign bus.iaddr     = (state_q == FETCH) ? missaddr_q : 32'h0;
  assign bus.misscount = misscount_q;

  // Next-state logic: start a fetch on a miss, finish it when memory answers;
  // flush always wins over a completing fill.
  always_comb begin
    state_d     = state_q;
    missaddr_d  = missaddr_q;
    misscount_d = misscount_q;
    fill        = 1'b0;
    case (state_q)
      IDLE: begin
        if (!bus.flush && bus.imemREN && !hit) begin
          missaddr_d = {bus.imemaddr[31:2], 2'b00};
          if (misscount_q != {CNTW{1'b1}}) begin
            misscount_d = misscount_q + CNT_ONE;
          end
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else if (!bus.iwait) begin
          fill    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers: state, latched miss address and miss counter.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      missaddr_q  <= 32'h0;
      misscount_q <= '0;
    end else begin
      state_q     <= state_d;
      missaddr_q  <= missaddr_d;
      misscount_q <= misscount_d;
    end
  end

  // Entry storage: flush drops every valid bit, a fill writes one entry.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q <= '0;
      for (int i = 0; i < SETS; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= 32'h0;
      end
    end else if (bus.flush) begin
      valid_q <= '0;
    end else if (fill) begin
      valid_q[miss_idx] <= 1'b1;
      tag_q[miss_idx]   <= miss_tag;
      data_q[miss_idx]  <= bus.iload;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_icache.sv
`default_nettype none
// ============================================================================
//  Module   : tb_icache
//  Purpose  : Self-checking bench for icache. Two caches (16-bit and 4-bit
//             miss counters) share one stimulus stream and are compared
//             against a word-address based reference model every cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_icache;

  localparam int SETS = 16;
  localparam int IDXW = $clog2(SETS);

  logic CLK  = 1'b0;
  logic nRST = 1'b1;
  always #5 CLK = ~CLK;

  logic        imemREN  = 1'b0;
  logic [31:0] imemaddr = 32'h0;
  logic        flush    = 1'b0;
  logic        iwait    = 1'b1;
  logic [31:0] iload    = 32'h0;

  icache_if #(.CNTW(16)) bus16 ();
  icache_if #(.CNTW(4))  bus4  ();

  assign bus16.imemREN  = imemREN;
  assign bus16.imemaddr = imemaddr;
  assign bus16.flush    = flush;
  assign bus16.iwait    = iwait;
  assign bus16.iload    = iload;
  assign bus4.imemREN   = imemREN;
  assign bus4.imemaddr  = imemaddr;
  assign bus4.flush     = flush;
  assign bus4.iwait     = iwait;
  assign bus4.iload     = iload;

  icache #(.SETS(SETS), .CNTW(16)) dut16 (.CLK(CLK), .nRST(nRST), .bus(bus16.slave));
  icache #(.SETS(SETS), .CNTW(4))  dut4  (.CLK(CLK), .nRST(nRST), .bus(bus4.slave));

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (word-address keyed) ----------------
  bit          m_valid [SETS];
  logic [29:0] m_word  [SETS];
  logic [31:0] m_data  [SETS];
  bit          m_fetch;
  logic [31:0] m_miss;
  int          m_misses;

  function automatic int slot(input logic [31:0] a);
    return int'((a >> 2) % SETS);
  endfunction

  function automatic bit exp_hit();
    return imemREN && !m_fetch && m_valid[slot(imemaddr)]
           && (m_word[slot(imemaddr)] == imemaddr[31:2]);
  endfunction

  function automatic logic [31:0] exp_cnt(input int w);
    longint lim;
    lim = (longint'(1) << w) - 1;
    return (m_misses > lim) ? 32'(lim) : 32'(m_misses);
  endfunction

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < SETS; i++) m_valid[i] <= 1'b0;
      m_fetch  <= 1'b0;
      m_miss   <= 32'h0;
      m_misses <= 0;
    end else if (!m_fetch) begin
      if (flush) begin
        for (int i = 0; i < SETS; i++) m_valid[i] <= 1'b0;
      end else if (imemREN && !exp_hit()) begin
        m_fetch  <= 1'b1;
        m_miss   <= {imemaddr[31:2], 2'b00};
        m_misses <= m_misses + 1;
      end
    end else begin
      if (flush) begin
        for (int i = 0; i < SETS; i++) m_valid[i] <= 1'b0;
        m_fetch <= 1'b0;
      end else if (!iwait) begin
        m_valid[slot(m_miss)] <= 1'b1;
        m_word[slot(m_miss)]  <= m_miss[31:2];
        m_data[slot(m_miss)]  <= iload;
        m_fetch               <= 1'b0;
      end
    end
  end

  // Every-cycle comparison of both caches against the model.
  always @(negedge CLK) begin
    if (cmp_en) begin
      chk("ihit",        32'(bus16.ihit), 32'(exp_hit()));
      chk("imemload",    bus16.imemload, exp_hit() ? m_data[slot(imemaddr)] : 32'h0);
      chk("iREN",        32'(bus16.iREN), 32'(m_fetch));
      chk("iaddr",       bus16.iaddr, m_fetch ? m_miss : 32'h0);
      chk("misscount16", 32'(bus16.misscount), exp_cnt(16));
      chk("misscount4",  32'(bus4.misscount), exp_cnt(4));
      chk("ihit4",       32'(bus4.ihit), 32'(exp_hit()));
      chk("iaddr4",      bus4.iaddr, m_fetch ? m_miss : 32'h0);
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #2 nRST = 1'b0;
    cmp_en = 1'b1;
    #1;
    chk("rst_iREN", 32'(bus16.iREN), 32'h0);
    chk("rst_misscount", 32'(bus16.misscount), 32'h0);
    repeat (3) @(posedge CLK);
    #2 nRST = 1'b1;
    step();

    // Cold miss on 0x40.
    imemREN = 1'b1; imemaddr = 32'h40;
    @(negedge CLK); chk("cold_ihit0", 32'(bus16.ihit), 32'h0);
    step();
    @(negedge CLK);
    chk("cold_iREN", 32'(bus16.iREN), 32'h1);
    chk("cold_iaddr", bus16.iaddr, 32'h40);
    iwait = 1'b0; iload = 32'h2001000A;
    step(); iwait = 1'b1;
    @(negedge CLK);
    chk("cold_ihit", 32'(bus16.ihit), 32'h1);
    chk("cold_load", bus16.imemload, 32'h2001000A);
    chk("cold_cnt", 32'(bus16.misscount), 32'h1);

    // Conflict miss: 0x80 evicts 0x40.
    imemaddr = 32'h80;
    @(negedge CLK); chk("conf_ihit0", 32'(bus16.ihit), 32'h0);
    step();
    @(negedge CLK); chk("conf_iaddr", bus16.iaddr, 32'h80);
    iwait = 1'b0; iload = 32'h80808080;
    step(); iwait = 1'b1; imemaddr = 32'h40;
    @(negedge CLK); chk("conf_evict", 32'(bus16.ihit), 32'h0);
    step();
    iwait = 1'b0; iload = 32'h2001000A;
    step(); iwait = 1'b1;
    @(negedge CLK);
    chk("conf_rehit", 32'(bus16.ihit), 32'h1);
    chk("conf_cnt", 32'(bus16.misscount), 32'h3);

    // Arbitration stall of 5 cycles on 0x300.
    imemaddr = 32'h300;
    step();
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("stall_iREN", 32'(bus16.iREN), 32'h1);
      chk("stall_iaddr", bus16.iaddr, 32'h300);
      chk("stall_ihit", 32'(bus16.ihit), 32'h0);
      step();
    end
    iwait = 1'b0; iload = 32'hCAFE0300;
    step(); iwait = 1'b1;
    @(negedge CLK);
    chk("stall_hit", 32'(bus16.ihit), 32'h1);
    chk("stall_load", bus16.imemload, 32'hCAFE0300);

    // Flush coinciding with the memory answer.
    imemaddr = 32'h0;
    step();
    iwait = 1'b0; iload = 32'h11110000;
    step(); iwait = 1'b1;
    @(negedge CLK); chk("flush_prehit", 32'(bus16.ihit), 32'h1);
    imemaddr = 32'h14;
    step();
    flush = 1'b1; iwait = 1'b0; iload = 32'hDEADBEEF;
    step();
    flush = 1'b0; iwait = 1'b1; imemREN = 1'b0;
    @(negedge CLK); chk("flush_idle", 32'(bus16.iREN), 32'h0);
    imemREN = 1'b1; imemaddr = 32'h0;
    #1 chk("flush_miss0", 32'(bus16.ihit), 32'h0);
    imemREN = 1'b0;
    step();

    // Datapath address moves during a fetch.
    imemREN = 1'b1; imemaddr = 32'h100;
    step();
    imemaddr = 32'h200;
    @(negedge CLK); chk("move_iaddr", bus16.iaddr, 32'h100);
    iwait = 1'b0; iload = 32'h01000100;
    step(); iwait = 1'b1;
    @(negedge CLK); chk("move_miss200", 32'(bus16.ihit), 32'h0);
    imemaddr = 32'h100;
    #1;
    chk("move_hit100", 32'(bus16.ihit), 32'h1);
    chk("move_load", bus16.imemload, 32'h01000100);
    imemREN = 1'b0;
    step();

    // Reset in the middle of a fetch.
    imemREN = 1'b1; imemaddr = 32'h44;
    step();
    iwait = 1'b0; iload = 32'h44444444;
    #1 nRST = 1'b0;
    #1;
    chk("rstf_iREN", 32'(bus16.iREN), 32'h0);
    chk("rstf_cnt", 32'(bus16.misscount), 32'h0);
    iwait = 1'b1;
    @(negedge CLK); nRST = 1'b1;
    #1 chk("rstf_remiss", 32'(bus16.ihit), 32'h0);

    // Twenty distinct misses to saturate the narrow counter.
    for (int i = 0; i < 20; i++) begin
      imemaddr = 32'h1000 * (i + 1) + 32'h8;
      step();
      iwait = 1'b0; iload = 32'(i);
      step(); iwait = 1'b1;
    end
    imemREN = 1'b0;
    @(negedge CLK);
    chk("sat_cnt4", 32'(bus4.misscount), 32'hF);
    chk("sat_cnt16", 32'(bus16.misscount), 32'd20);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      imemREN  = ($urandom % 10) < 8;
      imemaddr = (($urandom % 4) << (IDXW + 2)) | (($urandom % SETS) << 2)
               | ($urandom % 4) | (($urandom % 2) << 31);
      flush    = ($urandom % 40) == 0;
      iwait    = $urandom % 2;
      iload    = $urandom;
      step();
    end
    imemREN = 1'b0; flush = 1'b0; iwait = 1'b1;
    step();
    @(negedge CLK);
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
